dadda_multiplier: RTL and testbench

Unsigned 16×16-bit multiplier that produces a 32-bit product. It builds the partial-product matrix and reduces it with a Dadda tree of full and half adders, then resolves the last two rows with a carry-propagate adder. It is a drop-in arithmetic datapath block. The result is registered, so the multiply costs exactly one clock cycle of latency.

---
 rtl/dadda_pkg.sv | 74 +++++++
 rtl/dadda_multiplier_full_adder.sv | 13 +
 rtl/dadda_multiplier.sv | 123 ++++++++++++
 tb/tb_dadda_multiplier.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dadda_pkg.sv
// Shared widths and Dadda reduction plan for the 16x16 unsigned multiplier.
// The plan functions are evaluated at elaboration time to size every stage and column.
package dadda_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int NSTAGE = 6;
    localparam int MAXH   = 16;

    localparam int STAGE_D [NSTAGE] = '{13, 9, 6, 4, 3, 2};

    typedef enum int {
        PLAN_H,
        PLAN_FA,
        PLAN_HA
    } plan_sel_e;

    // Number of partial-product bits landing in a column of the initial matrix.
    function automatic int init_height(input int col);
        int res;
        res = 0;
        if (col < OP_W) begin
            res = col + 1;
        end else if (col < PROD_W - 1) begin
            res = PROD_W - 1 - col;
        end
        return res;
    endfunction

    // Column height entering a stage, or the full/half adder count used in it.
    // A column only gets as many adders as needed to reach the stage limit,
    // counting the carries arriving from the column below in the same stage.
    function automatic int dadda_plan(input int stage, input int col, input plan_sel_e sel);
        int h  [PROD_W];
        int nh [PROD_W];
        int cin;
        int excess;
        int fa;
        int ha;
        int res;
        res = 0;
        for (int c = 0; c < PROD_W; c++) begin
            h[c]  = init_height(c);
            nh[c] = 0;
        end
        for (int s = 0; s < NSTAGE; s++) begin
            if (s == stage && sel == PLAN_H) begin
                res = h[col];
            end
            cin = 0;
            for (int c = 0; c < PROD_W; c++) begin
                excess = h[c] + cin - STAGE_D[s];
                fa = (excess > 0) ? excess / 2 : 0;
                ha = (excess > 0) ? excess % 2 : 0;
                if (s == stage && c == col && sel == PLAN_FA) begin
                    res = fa;
                end
                if (s == stage && c == col && sel == PLAN_HA) begin
                    res = ha;
                end
                nh[c] = h[c] - 2 * fa - ha + cin;
                cin   = fa + ha;
            end
            for (int c = 0; c < PROD_W; c++) begin
                h[c] = nh[c];
            end
        end
        if (stage == NSTAGE && sel == PLAN_H) begin
            res = h[col];
        end
        return res;
    endfunction

endpackage

// File: rtl/dadda_multiplier_full_adder.sv
// 3:2 counter used for every reduction cell; half adders tie cin low.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/dadda_multiplier.sv
// Unsigned 16x16 -> 32 multiplier: AND matrix, six-stage Dadda tree, final adder,
// and a single output register giving one cycle of latency.
module dadda_multiplier
    import dadda_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    input  logic                in_valid,
    output logic [PROD_W-1:0]   product,
    output logic                out_valid
);

    // Column bits per stage; layer[s][c][k] is bit k of column c entering stage s.
    logic [MAXH-1:0] layer [NSTAGE+1][PROD_W];
    logic [MAXH-1:0] cy    [NSTAGE][PROD_W];

    logic [PROD_W-1:0] row0;
    logic [PROD_W-1:0] row1;
    logic [PROD_W-1:0] tree_sum;

    logic [PROD_W-1:0] product_q;
    logic [PROD_W-1:0] product_d;
    logic              valid_q;
    logic              valid_d;

    for (genvar c = 0; c < PROD_W; c++) begin : g_pp
        localparam int H0   = init_height(c);
        localparam int I_LO = (c < OP_W) ? 0 : c - (OP_W - 1);
        for (genvar k = 0; k < MAXH; k++) begin : g_bit
            if (k < H0) begin : g_and
                assign layer[0][c][k] = a[c - I_LO - k] & b[I_LO + k];
            end else begin : g_zero
                assign layer[0][c][k] = 1'b0;
            end
        end
    end

    // Output order per column: FA sums, HA sums, untouched bits, carries from below.
    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        for (genvar c = 0; c < PROD_W; c++) begin : g_col
            localparam int H     = dadda_plan(s, c, PLAN_H);
            localparam int NFA   = dadda_plan(s, c, PLAN_FA);
            localparam int NHA   = dadda_plan(s, c, PLAN_HA);
            localparam int PREV  = (c == 0) ? 0 : c - 1;
            localparam int CIN   = (c == 0) ? 0 :
                                   dadda_plan(s, PREV, PLAN_FA) + dadda_plan(s, PREV, PLAN_HA);
            localparam int NADD  = NFA + NHA;
            localparam int USED  = 3 * NFA + 2 * NHA;
            localparam int NPASS = H - USED;
            localparam int CYOFS = NADD + NPASS;
            localparam int HOUT  = CYOFS + CIN;

            for (genvar k = 0; k < NFA; k++) begin : g_fa
                full_adder u_fa (
                    .a    (layer[s][c][3*k]),
                    .b    (layer[s][c][3*k+1]),
                    .cin  (layer[s][c][3*k+2]),
                    .sum  (layer[s+1][c][k]),
                    .cout (cy[s][c][k])
                );
            end

            for (genvar k = 0; k < NHA; k++) begin : g_ha
                full_adder u_ha (
                    .a    (layer[s][c][3*NFA+2*k]),
                    .b    (layer[s][c][3*NFA+2*k+1]),
                    .cin  (1'b0),
                    .sum  (layer[s+1][c][NFA+k]),
                    .cout (cy[s][c][NFA+k])
                );
            end

            for (genvar k = 0; k < MAXH; k++) begin : g_route
                if (k >= NADD && k < CYOFS) begin : g_pass
                    assign layer[s+1][c][k] = layer[s][c][USED + k - NADD];
                end else if (k >= CYOFS && k < HOUT) begin : g_carry
                    assign layer[s+1][c][k] = cy[s][PREV][k - CYOFS];
                end else if (k >= HOUT) begin : g_zero
                    assign layer[s+1][c][k] = 1'b0;
                end
                if (k >= NADD) begin : g_cy_zero
                    assign cy[s][c][k] = 1'b0;
                end
            end
        end
    end

    // Two rows remain; carry out of bit 31 cannot occur for 16x16 operands.
    always_comb begin
        row0 = '0;
        row1 = '0;
        for (int c = 0; c < PROD_W; c++) begin
            row0[c] = layer[NSTAGE][c][0];
            row1[c] = layer[NSTAGE][c][1];
        end
        tree_sum = row0 + row1;
    end

    always_comb begin
        product_d = product_q;
        valid_d   = 1'b0;
        if (in_valid) begin
            product_d = tree_sum;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign product   = product_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_dadda_multiplier.sv
// Self-checking bench for dadda_multiplier: directed table, hand sequences,
// and randomized traffic against a plain-arithmetic reference model.
module tb_dadda_multiplier;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic [31:0] product;
    logic        out_valid;

    int checks;
    int failures;

    logic [31:0] m_prod;
    logic        m_valid;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [8];

    dadda_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .product   (product),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint unsigned full;
        full = longint'(x) * longint'(y);
        return full[31:0];
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model at the edge, and leave time just past the edge.
    task automatic cycle(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y);
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        if (r) begin
            m_prod  = 32'h0;
            m_valid = 1'b0;
        end else if (v) begin
            m_prod  = ref_mul(x, y);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_prod   = 32'h0;
        m_valid  = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        vecs[0] = '{16'd2,     16'd8,     32'd16};
        vecs[1] = '{16'd164,   16'd165,   32'd27060};
        vecs[2] = '{16'h00FF,  16'h00AA,  32'h0000A956};
        vecs[3] = '{16'd200,   16'd1250,  32'd250000};
        vecs[4] = '{16'd0,     16'd25,    32'd0};
        vecs[5] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vecs[6] = '{16'hFFFF,  16'h0001,  32'h0000FFFF};
        vecs[7] = '{16'h8000,  16'h8000,  32'h40000000};

        cycle(1'b1, 1'b0, 16'h0, 16'h0);
        cycle(1'b1, 1'b1, 16'h1234, 16'h5678);
        chk32("reset_product", product, 32'h0);
        chk1("reset_valid", out_valid, 1'b0);

        foreach (vecs[i]) begin
            cycle(1'b0, 1'b1, vecs[i].a, vecs[i].b);
            chk32($sformatf("table_product[%0d]", i), product, vecs[i].p);
            chk1($sformatf("table_valid[%0d]", i), out_valid, 1'b1);
        end

        cycle(1'b0, 1'b1, 16'd164, 16'd165);
        chk32("gap_first", product, 32'd27060);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, 1'b0, 16'($urandom), 16'($urandom));
            chk32($sformatf("gap_hold[%0d]", g), product, 32'd27060);
            chk1($sformatf("gap_valid[%0d]", g), out_valid, 1'b0);
        end

        cycle(1'b0, 1'b1, 16'hBEEF, 16'h1234);
        chk32("pre_reset", product, 32'hBEEF * 32'h1234);
        cycle(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        chk32("reset_vs_valid_product", product, 32'h0);
        chk1("reset_vs_valid_valid", out_valid, 1'b0);
        cycle(1'b0, 1'b1, 16'd3, 16'd7);
        chk32("post_reset_product", product, 32'd21);
        chk1("post_reset_valid", out_valid, 1'b1);
        cycle(1'b1, 1'b0, 16'd0, 16'd0);
        chk32("midstream_reset", product, 32'h0);
        chk1("midstream_reset_valid", out_valid, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = 16'($urandom);
            y = 16'($urandom);
            cycle(1'b0, 1'b1, x, y);
            chk32("b2b_product", product, ref_mul(x, y));
            chk1("b2b_valid", out_valid, 1'b1);
        end

        for (int n = 0; n < 20000; n++) begin
            logic r;
            logic v;
            r = ($urandom_range(63) == 0);
            v = ($urandom_range(3) != 0);
            cycle(r, v, 16'($urandom), 16'($urandom));
            chk32("sweep_product", product, m_prod);
            chk1("sweep_valid", out_valid, m_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
